// File: rtl/sram_zbt_ctrl_if.sv
// Request/response bus between the SRAM arbiter (master) and the ZBT
// controller (slave).
//
// Handshake: a request is taken at every rising edge where sram_addr_valid=1
// and sram_ready=1. There is no other backpressure, so a new request can be
// taken on every cycle. A request presented while sram_ready=0 is discarded
// and flagged by the controller. Read data comes back exactly 3 cycles after
// the request, as a one-cycle sram_data_out_valid strobe. There is no ready on
// the response side.
interface sram_zbt_ctrl_if #(
  parameter int ADDR_W = 18
) ();
  logic              sram_addr_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_data_in;
  logic [3:0]        sram_write_mask;
  logic              sram_ready;
  logic [31:0]       sram_data_out;
  logic              sram_data_out_valid;

  modport master (
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  sram_ready, sram_data_out, sram_data_out_valid
  );

  modport slave (
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output sram_ready, sram_data_out, sram_data_out_valid
  );
endinterface

// File: rtl/sram_zbt_ctrl.sv
// Pipelined ZBT SSRAM controller.
// A request is taken in cycle t. The address and control pins show it in t+1.
// The device data phase is t+2. Read data is returned in t+3.
// Every pin output and every response output comes straight from a flop.
module sram_zbt_ctrl #(
  parameter int INIT_CYCLES = 16,
  parameter int ADDR_W      = 18
) (
  input  logic              sram_clock,
  input  logic              reset,
  sram_zbt_ctrl_if.slave    req,
  output logic              req_dropped_o,
  output logic [ADDR_W-1:0] pin_a_o,
  output logic              pin_ce_n_o,
  output logic              pin_adv_ld_n_o,
  output logic              pin_we_n_o,
  output logic              pin_oe_n_o,
  output logic [3:0]        pin_bw_n_o,
  output logic [31:0]       pin_dq_o,
  output logic              pin_dq_oe_o,
  input  logic [31:0]       pin_dq_i,
  output logic              dbg_state_o
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run;
  logic accept;
  logic drop_now;
  logic is_write;

  // Address stage: pin registers plus the tag for the transaction.
  logic [ADDR_W-1:0] a_q, a_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        bw_n_q, bw_n_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_read_q, s1_read_d;
  logic [31:0]       s1_data_q, s1_data_d;

  // Data stage: pad drive and output-enable registers, plus the read tag.
  logic [31:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              oe_n_q, oe_n_d;
  logic              s2_read_q, s2_read_d;

  // Return stage.
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              dropped_q, dropped_d;

  // State register: reset returns to INIT with the settle counter reloaded.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down in INIT, leave INIT the cycle after the counter reads 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // State outputs: ready, request acceptance, and drop detection.
  always_comb begin
    run      = (state_q == S_RUN);
    accept   = req.sram_addr_valid && run;
    drop_now = req.sram_addr_valid && !run;
    is_write = (req.sram_write_mask != 4'h0);
  end

  // Next values for the address stage. pin_a holds while the stage is idle.
  always_comb begin
    a_d        = a_q;
    ce_n_d     = 1'b1;
    we_n_d     = 1'b1;
    bw_n_d     = 4'hF;
    s1_valid_d = accept;
    s1_read_d  = 1'b0;
    s1_data_d  = s1_data_q;
    if (accept) begin
      a_d       = req.sram_addr;
      ce_n_d    = 1'b0;
      we_n_d    = ~is_write;
      bw_n_d    = is_write ? ~req.sram_write_mask : 4'hF;
      s1_read_d = ~is_write;
      s1_data_d = req.sram_data_in;
    end
  end

  // Next values for the data stage. Only a write drives the pad and only a
  // read opens the device output, so the pad is never driven in a read cycle.
  always_comb begin
    dq_oe_d   = s1_valid_q && !s1_read_q;
    oe_n_d    = !(s1_valid_q && s1_read_q);
    s2_read_d = s1_valid_q && s1_read_q;
    dq_o_d    = dq_o_q;
    if (s1_valid_q && !s1_read_q) dq_o_d = s1_data_q;
  end

  // Next values for the return stage. The device data is captured at the edge
  // that closes a read data phase. The read data holds while no read returns.
  always_comb begin
    rvalid_d  = s2_read_q;
    rdata_d   = s2_read_q ? pin_dq_i : rdata_q;
    dropped_d = dropped_q | drop_now;
  end

  // Pipeline registers. Reset clears all in-flight tags at once.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      a_q        <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      bw_n_q     <= 4'hF;
      s1_valid_q <= 1'b0;
      s1_read_q  <= 1'b0;
      s1_data_q  <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      s2_read_q  <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      a_q        <= a_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      bw_n_q     <= bw_n_d;
      s1_valid_q <= s1_valid_d;
      s1_read_q  <= s1_read_d;
      s1_data_q  <= s1_data_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      oe_n_q     <= oe_n_d;
      s2_read_q  <= s2_read_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      dropped_q  <= dropped_d;
    end
  end

  // Output wiring. ADV/LD is tied low: every access is a fresh load, and an
  // idle cycle is a deselect.
  assign req.sram_ready          = run;
  assign req.sram_data_out       = rdata_q;
  assign req.sram_data_out_valid = rvalid_q;
  assign req_dropped_o           = dropped_q;
  assign pin_a_o                 = a_q;
  assign pin_ce_n_o              = ce_n_q;
  assign pin_adv_ld_n_o          = 1'b0;
  assign pin_we_n_o              = we_n_q;
  assign pin_oe_n_o              = oe_n_q;
  assign pin_bw_n_o              = bw_n_q;
  assign pin_dq_o                = dq_o_q;
  assign pin_dq_oe_o             = dq_oe_q;
  assign dbg_state_o             = state_q;

endmodule
